// File: rtl/div_pkg.sv
// Shared definitions for the mult/div unit: divider FSM states, the default
// datapath width, and a small helper for operand sign handling.
package div_pkg;

    // Default operand width shared by the multiplier and divider.
    localparam int DIV_W_DEFAULT = 32;

    // Divider control states: waiting, iterating, result sign fix-up.
    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } div_state_t;

    // An operand needs negating to get its magnitude only in signed mode
    // and only when its MSB is set.
    function automatic logic needNeg(input logic signedMode, input logic msb);
        return signedMode & msb;
    endfunction

endpackage

// File: rtl/div_seq_param_if.sv
// Handshake and data bus between the control unit (master) and the
// sequential divider (slave).
interface div_seq_param_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W_DEFAULT
) ();

    logic             div_start;
    logic             div_signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             div_end;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic             div_0_exception;

    // Control unit side: issues requests, observes status and results.
    modport master (
        output div_start,
        output div_signed,
        output A,
        output B,
        input  busy,
        input  div_end,
        input  HI,
        input  LO,
        input  div_0_exception
    );

    // Divider side: consumes requests, produces status and results.
    modport slave (
        input  div_start,
        input  div_signed,
        input  A,
        input  B,
        output busy,
        output div_end,
        output HI,
        output LO,
        output div_0_exception
    );

endinterface

// File: rtl/div_sign_fix.sv
// Two-lane conditional two's-complement negate. Used once to turn operands
// into magnitudes and once to give the quotient/remainder their final signs.
module div_sign_fix
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W_DEFAULT
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic             negA_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             negB_i,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o
);

    // Negation wraps for the most negative value, which is exactly the
    // unsigned magnitude we want, so no extra width is required.
    always_comb begin
        a_o = negA_i ? (~a_i + {{(WIDTH-1){1'b0}}, 1'b1}) : a_i;
        b_o = negB_i ? (~b_i + {{(WIDTH-1){1'b0}}, 1'b1}) : b_i;
    end

endmodule

// File: rtl/div_seq_param.sv
// Radix-2 restoring divider, one quotient bit per clock. Signed or unsigned,
// quotient to LO and remainder to HI, with a fast divide-by-zero exit.
module div_seq_param
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_W_DEFAULT,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic           clock,
    input  logic           reset,
    div_seq_param_if.slave bus
);

    div_state_t        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [WIDTH-1:0]  rem_q;
    logic [WIDTH-1:0]  quo_q;
    logic [WIDTH-1:0]  dvs_q;
    logic              signMode_q;
    logic              signA_q;
    logic              signB_q;
    logic              zeroPend_q;
    logic              busy_q;
    logic              divEnd_q;
    logic              div0_q;
    logic [WIDTH-1:0]  hi_q;
    logic [WIDTH-1:0]  lo_q;

    logic [WIDTH-1:0]  magA;
    logic [WIDTH-1:0]  magB;
    logic [WIDTH:0]    shifted;
    logic [WIDTH:0]    trial;
    logic              trialNeg;
    logic [WIDTH-1:0]  rem_d;
    logic [WIDTH-1:0]  quo_d;
    logic              negQuo;
    logic              negRem;
    logic [WIDTH-1:0]  resQuo;
    logic [WIDTH-1:0]  resRem;

    // Operand magnitudes straight from the bus, used only on acceptance.
    div_sign_fix #(.WIDTH(WIDTH)) u_opFix (
        .a_i    (bus.A),
        .negA_i (needNeg(bus.div_signed, bus.A[WIDTH-1])),
        .b_i    (bus.B),
        .negB_i (needNeg(bus.div_signed, bus.B[WIDTH-1])),
        .a_o    (magA),
        .b_o    (magB)
    );

    // One restoring step: shift the next dividend bit into the partial
    // remainder, trial-subtract one bit wider so the borrow shows the sign.
    always_comb begin
        shifted  = {rem_q, quo_q[WIDTH-1]};
        trial    = shifted - {1'b0, dvs_q};
        trialNeg = trial[WIDTH];
        rem_d    = trialNeg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d    = {quo_q[WIDTH-2:0], ~trialNeg};
    end

    // Quotient is negative when signs differ; remainder follows the dividend.
    always_comb begin
        negQuo = signMode_q & (signA_q ^ signB_q);
        negRem = signMode_q & signA_q;
    end

    div_sign_fix #(.WIDTH(WIDTH)) u_resFix (
        .a_i    (quo_q),
        .negA_i (negQuo),
        .b_i    (rem_q),
        .negB_i (negRem),
        .a_o    (resQuo),
        .b_o    (resRem)
    );

    // Control FSM and datapath registers; all outputs are registered and
    // a zero divisor takes a one-cycle detour through zeroPend_q.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            signMode_q <= 1'b0;
            signA_q    <= 1'b0;
            signB_q    <= 1'b0;
            zeroPend_q <= 1'b0;
            busy_q     <= 1'b0;
            divEnd_q   <= 1'b0;
            div0_q     <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            divEnd_q <= 1'b0;
            div0_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (zeroPend_q) begin
                        divEnd_q <= 1'b1;
                        div0_q   <= 1'b1;
                    end
                    zeroPend_q <= 1'b0;
                    if (bus.div_start) begin
                        if (bus.B == '0) begin
                            zeroPend_q <= 1'b1;
                        end else begin
                            signMode_q <= bus.div_signed;
                            signA_q    <= bus.A[WIDTH-1];
                            signB_q    <= bus.B[WIDTH-1];
                            rem_q      <= '0;
                            quo_q      <= magA;
                            dvs_q      <= magB;
                            cnt_q      <= CNT_W'(WIDTH);
                            busy_q     <= 1'b1;
                            state_q    <= CALC;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FIX;
                    end
                end
                FIX: begin
                    lo_q     <= resQuo;
                    hi_q     <= resRem;
                    divEnd_q <= 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy            = busy_q;
    assign bus.div_end         = divEnd_q;
    assign bus.div_0_exception = div0_q;
    assign bus.HI              = hi_q;
    assign bus.LO              = lo_q;

endmodule
